// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM state
// encodings, grant encodings and the one-hot-to-grant helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Grant encoding doubles as the bit index into the {d, i} request vector.
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int CNT_W = 3;

  function automatic gnt_e onehot_to_gnt(input logic [1:0] gnt);
    return (gnt == 2'b10) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational. A lone request wins
// outright; on contention the requester that did not win last time wins.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  gnt_e       last_grant,
  output logic [1:0] gnt
);

  // One-hot grant: pass single requests through, alternate on a tie.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_grant == GNT_D) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between an instruction-fetch port and a
// load/store port. Each transaction walks IDLE -> ISSUE -> WAIT -> RESP;
// requests are only looked at in IDLE, so a transaction is never preempted.
// Handshake: a requester raises req with stable address/data and holds it
// until its one-cycle valid pulse, then drops req in the following cycle.
// MEM_LATENCY must lie in 1..7 (it is loaded into a 3-bit counter).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_valid,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_valid,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  gnt_e                    win_q, win_d;
  gnt_e                    last_q, last_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              wmask_q, wmask_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             i_rdata_q, i_rdata_d;
  logic [31:0]             d_rdata_q, d_rdata_d;
  logic [1:0]              gnt;
  gnt_e                    gnt_sel;

  rr_arbiter2 u_arb (
    .req        ({d_req, i_req}),
    .last_grant (last_q),
    .gnt        (gnt)
  );

  assign gnt_sel = onehot_to_gnt(gnt);

  // Next-state, winner latch, latency counter and read-data capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wmask_d   = wmask_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt != 2'b00) begin
          state_d = ST_ISSUE;
          win_d   = gnt_sel;
          last_d  = gnt_sel;
          if (gnt_sel == GNT_D) begin
            addr_d  = d_addr;
            wmask_d = d_wmask;
            wdata_d = d_wdata;
          end else begin
            // Fetches never write.
            addr_d  = i_addr;
            wmask_d = 4'b0000;
            wdata_d = 32'h0;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        // The decrement that lands on zero coincides with read data arriving.
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = ST_RESP;
          if (win_q == GNT_D) d_rdata_d = mem_rdata;
          else                i_rdata_d = mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any
  // transaction in flight and favours fetch on the first contention.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      win_q     <= GNT_I;
      last_q    <= GNT_D;
      addr_q    <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_valid   = (state_q == ST_RESP) && (win_q == GNT_I);
  assign d_valid   = (state_q == ST_RESP) && (win_q == GNT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance at MEM_LATENCY=1 for arbitration,
// store and reset scenarios, one at MEM_LATENCY=3 for the latency scenario.
module tb_mem_port_arbiter;

  localparam int AW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (latency 1) ----------------
  logic          i_req = 0, d_req = 0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [3:0]    d_wmask = '0;
  logic [31:0]   d_wdata = '0;
  logic [31:0]   i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_valid, d_valid, mem_en;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_wmask;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_addr(d_addr), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- DUT (latency 3) ----------------
  logic          i3_req = 0, d3_req = 0;
  logic [AW-1:0] i3_addr = '0, d3_addr = '0;
  logic [3:0]    d3_wmask = '0;
  logic [31:0]   d3_wdata = '0;
  logic [31:0]   i3_rdata, d3_rdata, mem3_wdata, mem3_rdata;
  logic          i3_valid, d3_valid, mem3_en;
  logic [AW-1:0] mem3_addr;
  logic [3:0]    mem3_wmask;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .i_req(i3_req), .i_addr(i3_addr), .i_rdata(i3_rdata), .i_valid(i3_valid),
    .d_req(d3_req), .d_addr(d3_addr), .d_wmask(d3_wmask), .d_wdata(d3_wdata),
    .d_rdata(d3_rdata), .d_valid(d3_valid),
    .mem_en(mem3_en), .mem_addr(mem3_addr), .mem_wmask(mem3_wmask),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] data_for(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'h0000_0013;
    return {16'hC0DE, a};
  endfunction

  // Read data appears exactly MEM_LATENCY cycles after mem_en; other cycles
  // carry junk so a mistimed capture is visible.
  always @(posedge clk) begin
    mem_rdata <= mem_en ? data_for(mem_addr) : (32'hBAD0_0000 | 32'(cyc[15:0]));
  end

  logic [31:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= mem3_en ? data_for(mem3_addr) : (32'hBAD3_0000 | 32'(cyc[15:0]));
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem3_rdata = p3[2];

  // ---------------- scoreboard ----------------
  // exp_q: {cycle, port(1=data), rdata}; en_q: {cycle, addr, wmask, wdata}
  logic [64:0] exp_q[$];
  logic [83:0] en_q[$];
  logic [64:0] exp3_q[$];
  logic [83:0] en3_q[$];
  logic [31:0] zero_q[$];
  logic [63:0] hold_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit done = 0;
  bit finished = 0;
  logic [64:0] e_v;
  logic [83:0] e_en;
  logic [63:0] e_h;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a valid or mem_en.
  always @(negedge clk) begin
    check("one_valid_at_a_time", {63'd0, i_valid & d_valid}, 64'd0);
    if (i_valid || d_valid) begin
      check("valid_expected", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        e_v = exp_q.pop_front();
        check("valid_cycle", 64'(cyc), 64'(e_v[64:33]));
        check("valid_port", {63'd0, d_valid}, {63'd0, e_v[32]});
        check("rdata", 64'(d_valid ? d_rdata : i_rdata), 64'(e_v[31:0]));
      end
    end
    if (mem_en) begin
      check("mem_en_expected", {63'd0, en_q.size() > 0}, 64'd1);
      if (en_q.size() > 0) begin
        e_en = en_q.pop_front();
        check("mem_en_cycle", 64'(cyc), 64'(e_en[83:52]));
        check("mem_addr", 64'(mem_addr), 64'(e_en[51:36]));
        check("mem_wmask", 64'(mem_wmask), 64'(e_en[35:32]));
        check("mem_wdata", 64'(mem_wdata), 64'(e_en[31:0]));
      end
    end
    if (zero_q.size() > 0 && zero_q[0] == 32'(cyc)) begin
      void'(zero_q.pop_front());
      check("zero_ctrl", {61'd0, i_valid, d_valid, mem_en}, 64'd0);
      check("zero_mem", {12'd0, mem_addr, mem_wmask, mem_wdata}, 64'd0);
      check("zero_rdata", {i_rdata, d_rdata}, 64'd0);
    end
    if (hold_q.size() > 0 && hold_q[0][63:32] == 32'(cyc)) begin
      e_h = hold_q.pop_front();
      check("i_rdata_hold", 64'(i_rdata), 64'(e_h[31:0]));
    end
    check("lat3_no_fetch_valid", {63'd0, i3_valid}, 64'd0);
    if (d3_valid) begin
      check("lat3_valid_expected", {63'd0, exp3_q.size() > 0}, 64'd1);
      if (exp3_q.size() > 0) begin
        e_v = exp3_q.pop_front();
        check("lat3_valid_cycle", 64'(cyc), 64'(e_v[64:33]));
        check("lat3_rdata", 64'(d3_rdata), 64'(e_v[31:0]));
      end
    end
    if (mem3_en) begin
      check("lat3_mem_en_expected", {63'd0, en3_q.size() > 0}, 64'd1);
      if (en3_q.size() > 0) begin
        e_en = en3_q.pop_front();
        check("lat3_mem_en_cycle", 64'(cyc), 64'(e_en[83:52]));
        check("lat3_mem_addr", 64'(mem3_addr), 64'(e_en[51:36]));
      end
    end
    if (done && !finished) begin
      check("left_valid", 64'(exp_q.size()), 64'd0);
      check("left_mem_en", 64'(en_q.size()), 64'd0);
      check("left_lat3", 64'(exp3_q.size() + en3_q.size()), 64'd0);
      check("left_zero_hold", 64'(zero_q.size() + hold_q.size()), 64'd0);
      finished = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_en(input int c, input logic [AW-1:0] a, input logic [3:0] m,
                         input logic [31:0] w);
    en_q.push_back({32'(c), a, m, w});
  endtask

  task automatic push_valid(input int c, input bit port_d, input logic [31:0] d);
    exp_q.push_back({32'(c), port_d, d});
  endtask

  // Waits (bounded) for the selected valid pulse, then drops that request.
  task automatic wait_valid(input bit on_d);
    int n = 0;
    while (!(on_d ? d_valid : i_valid) && n < 30) begin
      tick();
      n++;
    end
    tick();
    if (on_d) d_req = 0;
    else      i_req = 0;
  endtask

  task automatic wait_valid3();
    int n = 0;
    while (!d3_valid && n < 30) begin
      tick();
      n++;
    end
    tick();
    d3_req = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    tick();
    zero_q.push_back(32'(cyc));
    reset = 1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c;
    tick();
    do_reset();

    // Single fetch at latency 1: mem_en in cycle 1, i_valid in cycle 3.
    c = cyc;
    i_addr = 16'h0010; i_req = 1;
    push_en(c + 1, 16'h0010, 4'h0, 32'h0);
    push_valid(c + 3, 0, 32'h0000_0013);
    wait_valid(0);
    hold_q.push_back({32'(cyc), 32'h0000_0013});
    tick();

    // Contended pair straight after reset: fetch first, data after one idle cycle.
    do_reset();
    c = cyc;
    i_addr = 16'h0020; d_addr = 16'h0030; d_wmask = 4'h0; d_wdata = 32'h0;
    i_req = 1; d_req = 1;
    push_en(c + 1, 16'h0020, 4'h0, 32'h0);
    push_valid(c + 3, 0, 32'hC0DE_0020);
    push_en(c + 5, 16'h0030, 4'h0, 32'h0);
    push_valid(c + 7, 1, 32'hC0DE_0030);
    wait_valid(0);
    wait_valid(1);

    // Lone fetch moves the last grant to fetch.
    c = cyc;
    i_addr = 16'h0022; i_req = 1;
    push_en(c + 1, 16'h0022, 4'h0, 32'h0);
    push_valid(c + 3, 0, 32'hC0DE_0022);
    wait_valid(0);

    // Second contended pair: data wins this time.
    c = cyc;
    i_addr = 16'h0024; d_addr = 16'h0034;
    i_req = 1; d_req = 1;
    push_en(c + 1, 16'h0034, 4'h0, 32'h0);
    push_valid(c + 3, 1, 32'hC0DE_0034);
    push_en(c + 5, 16'h0024, 4'h0, 32'h0);
    push_valid(c + 7, 0, 32'hC0DE_0024);
    wait_valid(1);
    wait_valid(0);

    // Store: mask and data reach the memory port; d_rdata gets memory read data.
    c = cyc;
    d_addr = 16'h0040; d_wmask = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_req = 1;
    push_en(c + 1, 16'h0040, 4'b0011, 32'hDEAD_BEEF);
    push_valid(c + 3, 1, 32'hC0DE_0040);
    wait_valid(1);
    hold_q.push_back({32'(cyc), 32'hC0DE_0024});
    d_wmask = 4'h0; d_wdata = 32'h0;
    tick();

    // Reset during WAIT: transaction abandoned, outputs cleared.
    c = cyc;
    i_addr = 16'h0050; i_req = 1;
    push_en(c + 1, 16'h0050, 4'h0, 32'h0);
    tick();
    tick();
    reset = 0; i_req = 0;
    tick();
    zero_q.push_back(32'(cyc));
    reset = 1;
    tick();

    // Fetch after the aborted transaction completes normally.
    c = cyc;
    i_addr = 16'h0010; i_req = 1;
    push_en(c + 1, 16'h0010, 4'h0, 32'h0);
    push_valid(c + 3, 0, 32'h0000_0013);
    wait_valid(0);
    tick();

    // Latency-3 load: single mem_en, d_valid 5 cycles after request.
    c = cyc;
    d3_addr = 16'h0060; d3_req = 1;
    en3_q.push_back({32'(c + 1), 16'h0060, 4'h0, 32'h0});
    exp3_q.push_back({32'(c + 5), 1'b1, 32'hC0DE_0060});
    wait_valid3();
    tick();
    tick();

    done = 1;
    for (int k = 0; k < 5 && !finished; k++) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
